tx_serial_param: RTL and testbench

Parametrised serial transmitter and successor to the fixed-format simple TX. It accepts a parallel word through a valid/ready handshake, captures it, and shifts it out on a single line. Each frame is start bit, data bits, optional parity, then one or two stop bits, and every bit lasts a configurable number of clocks. It sits between a word-level producer (register block or FIFO) and the serial pin.

---
 rtl/tx_serial_pkg.sv | 35 +++
 rtl/tx_baud_gen.sv | 46 ++++
 rtl/tx_serial_param.sv | 159 +++++++++++++++
 tb/tb_tx_serial_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_serial_pkg
// Brief    : Shared types, state encodings and parity helper for tx_serial_param.
// Revision : 1.0
// ============================================================================
package tx_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    // Unused upper bits must be zero; odd parity is the inverse of the XOR.
    function automatic logic calc_parity(input logic [31:0] word, input parity_t mode);
        return (^word) ^ (mode == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : tx_baud_gen
// Brief    : Bit-period counter; tick_o marks the last clock of each bit.
// Revision : 1.0
// ============================================================================
module tx_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("tx_baud_gen: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == c_cnt_last)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/tx_serial_param.sv
`default_nettype none
// ============================================================================
// Module   : tx_serial_param
// Brief    : Parametrised serial transmitter (start, data, parity, stop bits).
// Revision : 1.0
// ============================================================================
module tx_serial_param
    import tx_serial_pkg::*;
#(
    parameter int      DATA_W       = 9,
    parameter int      CLKS_PER_BIT = 16,
    parameter parity_t PARITY       = PAR_NONE,
    parameter int      STOP_BITS    = 1,
    parameter bit      LSB_FIRST    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int                 c_bit_w     = $clog2(DATA_W + 1);
    localparam logic [c_bit_w-1:0] c_last_data = c_bit_w'(DATA_W - 1);
    localparam logic [c_bit_w-1:0] c_last_stop = c_bit_w'(STOP_BITS - 1);
    localparam bit                 c_has_par   = (PARITY != PAR_NONE);

    generate
        if ((DATA_W < 1) || (DATA_W > 32)) begin : g_bad_data_w
            $error("tx_serial_param: DATA_W must be in 1..32");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
            $error("tx_serial_param: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("tx_serial_param: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [2:0]         state_q,   state_d;
    logic [DATA_W-1:0]  shift_q,   shift_d;
    logic [c_bit_w-1:0] bit_cnt_q, bit_cnt_d;
    logic               par_q,     par_d;
    logic               tx_q,      tx_d;
    logic               ready_q,   ready_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               w_tick;
    logic               w_state_chg;
    logic               w_baud_clr;

    tx_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_baud_clr),
        .tick_o (w_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        done_d    = 1'b0;

        case (state_q)
            c_st_idle: begin
                if (valid_i) begin
                    state_d = c_st_start;
                    shift_d = data_i;
                    par_d   = calc_parity(32'(data_i), PARITY);
                end
            end
            c_st_start: begin
                if (w_tick) begin
                    state_d = c_st_data;
                end
            end
            c_st_data: begin
                if (w_tick) begin
                    shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == c_last_data) begin
                        state_d = c_has_par ? c_st_parity : c_st_stop;
                    end
                end
            end
            c_st_parity: begin
                if (w_tick) begin
                    state_d = c_st_stop;
                end
            end
            c_st_stop: begin
                if (w_tick) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == c_last_stop) begin
                        state_d = c_st_idle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        w_state_chg = (state_d != state_q);
        if (w_state_chg) begin
            bit_cnt_d = '0;
        end
        w_baud_clr = w_state_chg || (state_q == c_st_idle);
    end

    // Outputs are decoded from next-state values so they change on the same edge as the state.
    always_comb begin
        case (state_d)
            c_st_start:  tx_d = 1'b0;
            c_st_data:   tx_d = LSB_FIRST ? shift_d[0] : shift_d[DATA_W-1];
            c_st_parity: tx_d = par_d;
            default:     tx_d = 1'b1;
        endcase
        ready_d = (state_d == c_st_idle);
        busy_d  = (state_d != c_st_idle);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= c_st_idle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_serial_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_serial_param
// Brief    : Self-checking bench over four transmitter configurations.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tx_serial_param;
    import tx_serial_pkg::*;

    localparam int NI  = 4;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] valid;
    logic [8:0]    data [NI];
    logic [NI-1:0] ready, tx, busy, done;

    always #5 clk = ~clk;

    tx_serial_param #(.DATA_W(9), .CLKS_PER_BIT(CPB), .PARITY(PAR_NONE), .STOP_BITS(1), .LSB_FIRST(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst), .data_i(data[0]), .valid_i(valid[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
    tx_serial_param #(.DATA_W(9), .CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN), .STOP_BITS(1), .LSB_FIRST(1'b1)) u1 (
        .clk_i(clk), .rst_i(rst), .data_i(data[1]), .valid_i(valid[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
    tx_serial_param #(.DATA_W(9), .CLKS_PER_BIT(CPB), .PARITY(PAR_ODD), .STOP_BITS(1), .LSB_FIRST(1'b1)) u2 (
        .clk_i(clk), .rst_i(rst), .data_i(data[2]), .valid_i(valid[2]),
        .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
    tx_serial_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_NONE), .STOP_BITS(2), .LSB_FIRST(1'b0)) u3 (
        .clk_i(clk), .rst_i(rst), .data_i(data[3][7:0]), .valid_i(valid[3]),
        .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));

    // Per-instance configuration, mirroring the parameters above.
    function automatic int cfg_w(input int i);    return (i == 3) ? 8 : 9; endfunction
    function automatic int cfg_par(input int i);  return (i == 1) ? 1 : ((i == 2) ? 2 : 0); endfunction
    function automatic int cfg_stop(input int i); return (i == 3) ? 2 : 1; endfunction
    function automatic bit cfg_lsb(input int i);  return (i != 3); endfunction
    function automatic int flen(input int i);
        return (1 + cfg_w(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i)) * CPB;
    endfunction

    // Line level of bit slot b of a frame carrying word w.
    function automatic logic frame_bit(input int i, input logic [8:0] w, input int b);
        int n;
        int ones;
        n = cfg_w(i);
        if (b == 0) return 1'b0;
        if (b <= n) return cfg_lsb(i) ? w[b-1] : w[n-b];
        if ((cfg_par(i) != 0) && (b == n + 1)) begin
            ones = 0;
            for (int j = 0; j < n; j++) ones += int'(w[j]);
            return ((ones % 2) == 1) ^ (cfg_par(i) == 2);
        end
        return 1'b1;
    endfunction

    int         n_checks = 0;
    int         n_err    = 0;
    bit         chk_en   = 1'b0;
    bit         m_act  [NI];
    int         m_t    [NI];
    int         m_acc  [NI];
    logic [8:0] m_word [NI];
    logic       e_tx   [NI];
    logic       e_rdy  [NI];
    logic       e_busy [NI];
    logic       e_done [NI];
    int         done_cnt [NI];

    task automatic check(input string nm, input int i, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d at %0t: got %b expected %b", nm, i, $time, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int i, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", nm, i, $time, got, exp);
        end
    endtask

    // Behavioural model: position within the frame counted in clocks since accept.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            e_done[i] = 1'b0;
            if (!rst) begin
                m_act[i] = 1'b0;
                m_t[i]   = 0;
            end else if (m_act[i]) begin
                m_t[i]++;
                if (m_t[i] == flen(i)) begin
                    m_act[i]  = 1'b0;
                    e_done[i] = 1'b1;
                end
            end else if (valid[i]) begin
                m_act[i]  = 1'b1;
                m_t[i]    = 0;
                m_word[i] = (cfg_w(i) == 8) ? {1'b0, data[i][7:0]} : data[i];
                m_acc[i]++;
            end
            e_tx[i]   = m_act[i] ? frame_bit(i, m_word[i], m_t[i] / CPB) : 1'b1;
            e_rdy[i]  = !m_act[i];
            e_busy[i] = m_act[i];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check("tx", i, tx[i], e_tx[i]);
                check("ready", i, ready[i], e_rdy[i]);
                check("busy", i, busy[i], e_busy[i]);
                check("done", i, done[i], e_done[i]);
                if (done[i] === 1'b1) done_cnt[i]++;
            end
        end
    end

    logic [10:0] pin0 = 11'b11001111000;
    logic [10:0] pin3 = 11'b11101001010;
    int          cyc;
    int          acc0 [NI];

    initial begin
        rst   = 1'b0;
        valid = '0;
        for (int i = 0; i < NI; i++) begin
            data[i]  = '0;
            m_acc[i] = 0;
            done_cnt[i] = 0;
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_tx", i, tx[i], 1'b1);
            check("reset_ready", i, ready[i], 1'b1);
            check("reset_busy", i, busy[i], 1'b0);
            check("reset_done", i, done[i], 1'b0);
        end

        // Single frame on all four configurations
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) data[i] = 9'b100111100;
        data[3] = 9'h0A5;
        valid   = '1;
        @(posedge clk);
        #1;
        valid = '0;
        for (int i = 0; i < NI; i++) data[i] = 9'($urandom);
        for (int b = 0; b <= 10; b++) begin
            repeat ((b == 0) ? 2 : 4) @(posedge clk);
            @(negedge clk);
            check("u0_midbit", b, tx[0], pin0[b]);
            check("u3_midbit", b, tx[3], pin3[b]);
        end
        check("u1_even_parity", 1, tx[1], 1'b1);
        check("u2_odd_parity", 2, tx[2], 1'b0);
        cyc = 42;
        while (done[0] !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check_int("u0_done_latency", 0, cyc, 44);
        check("u3_done_at_44", 3, done[3], 1'b1);
        while (done[1] !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check_int("u1_done_latency", 1, cyc, 48);

        // Back-to-back with data changing every clock
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            done_cnt[i] = 0;
            acc0[i]     = m_acc[i];
            data[i]     = 9'($urandom);
        end
        valid = '1;
        for (int j = 0; j < 101; j++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) data[i] = 9'($urandom);
        end
        valid = '0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_int("b2b_done_pulses", i, done_cnt[i], 3);
            check_int("b2b_accepts", i, m_acc[i] - acc0[i], 3);
        end

        // Reset during data bit 4, then a clean frame
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) data[i] = 9'h1C3;
        valid = '1;
        @(posedge clk);
        #1;
        valid = '0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) done_cnt[i] = 0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("midreset_tx", i, tx[i], 1'b1);
            check("midreset_ready", i, ready[i], 1'b1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_int("midreset_no_done", i, done_cnt[i], 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) data[i] = 9'h0B6;
        valid = '1;
        @(posedge clk);
        #1;
        valid = '0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_int("after_reset_done", i, done_cnt[i], 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
